expr_eval: RTL and testbench
============================

EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the result width in bits (legal 8..32).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 clr  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 in  input  8  ASCII character of the expression stream.
REQ-005 in_vld  input  1  when high, in SHALL be consumed on that edge; when low, in SHALL be ignored.
REQ-006 result  output  W  value of the longest valid expression prefix consumed so far, modulo 2^W.
REQ-007 res_vld  output  1  high while the consumed stream is a complete valid expression.
REQ-008 err  output  1  sticky flag for a grammar violation.
REQ-009 ovf  output  1  sticky flag for arithmetic overflow (see Configuration).

Function
REQ-010 The block SHALL accept the grammar digit ( op digit )*, where digit is '0'..'9' (48..57) and op is '+' (43) or '*' (42).
REQ-011 '*' SHALL bind tighter than '+'; evaluation SHALL proceed left to right.
REQ-012 The block SHALL have five states:
- S_START: expect the first digit.
- S_NUM: digit just seen; expect an op.
- S_ADD: '+' just seen; expect a digit.
- S_MUL: '*' just seen; expect a digit.
- S_ERR: absorbing.
REQ-013 Internal registers SHALL be sum (W bits, completed additive terms) and term (W bits, current product).
REQ-014 A digit d accepted in S_START SHALL set sum=0 and term=d, and move to S_NUM.
REQ-015 A digit d accepted in S_ADD SHALL set term=d and move to S_NUM.
REQ-016 A digit d accepted in S_MUL SHALL set term=term*d, truncated to W bits, and move to S_NUM.
REQ-017 '+' accepted in S_NUM SHALL set sum=sum+term, truncated to W bits, and move to S_ADD; '*' accepted in S_NUM SHALL move to S_MUL.
REQ-018 Any other accepted character, or any accepted character in the wrong state, SHALL move to S_ERR; err SHALL be set and res_vld cleared on the next edge.
REQ-019 S_ERR SHALL ignore all input until clr, with sum, term and result frozen.
REQ-020 Two consecutive digits SHALL be a grammar violation, i.e. multi-digit numbers are illegal.
REQ-021 On each accepted digit, result SHALL be registered as the new sum+term value, truncated to W bits; res_vld SHALL be 1 from the next edge.
REQ-022 On an accepted op, res_vld SHALL go to 0 on the next edge and result SHALL hold its previous value.
REQ-023 Latency from an accepted character to the updated outputs SHALL be exactly one clock.
REQ-024 Outputs SHALL change only on accepted characters or clr; in_vld low cycles SHALL leave all state unchanged.

Reset
REQ-025 With clr high at a clock edge, state SHALL become S_START and sum, term, result, res_vld, err and ovf SHALL become 0.
REQ-026 clr SHALL take priority over in_vld on the same edge; the character presented on that edge SHALL be discarded.
REQ-027 clr asserted mid-expression or in S_ERR SHALL fully restart evaluation; no state SHALL survive it.

Configuration
REQ-028 With macro EXPR_EVAL_OVF_EN defined, the block SHALL compute term*d in W+4 bits and sum+term in W+1 bits, and SHALL set ovf sticky when any truncation discards a nonzero bit.
REQ-029 When ovf is set, result SHALL continue to report the value modulo 2^W.
REQ-030 With EXPR_EVAL_OVF_EN undefined, ovf SHALL be tied to 0 and the widened arithmetic SHALL be omitted; all other behaviour SHALL be identical.

Verification
REQ-031 "1+2*3", one char per cycle, in_vld=1 -> one cycle after '3': result=7, res_vld=1, err=0.
REQ-032 "2*3+4" with in_vld=0 gaps of 2 cycles between chars -> final result=10, res_vld=1; outputs stable during gaps.
REQ-033 "5+" -> after '5': result=5, res_vld=1; after '+': res_vld=0, result=5. Then "7" -> result=12, res_vld=1.
REQ-034 "12" -> err=1, res_vld=0 one cycle after '2', result=1; further "+3" changes nothing.
REQ-035 W=16, "9*9*9*9*9" -> result=59049, ovf=0. Appending "*9" -> result=7153 and ovf=1 (with EXPR_EVAL_OVF_EN) or ovf=0 (without).
REQ-036 clr on the same edge as '*' after "3" -> all outputs 0 and state S_START; then "4" -> result=4, res_vld=1.

Source files
------------

// File: rtl/expr_eval.sv
// Streaming evaluator for "digit (op digit)*" over '+' and '*' with '*' binding tighter.
// Optional macro EXPR_EVAL_OVF_EN enables widened arithmetic and the sticky ovf flag.
module expr_eval #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [7:0]   in,
  input  logic         in_vld,
  output logic [W-1:0] result,
  output logic         res_vld,
  output logic         err,
  output logic         ovf
);

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_NUM   = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]   r_state;
  logic [W-1:0] r_sum;
  logic [W-1:0] r_term;
  logic [W-1:0] r_result;
  logic         r_res_vld;
  logic         r_err;

  logic         w_is_digit;
  logic [W-1:0] w_digit;
  logic [W-1:0] w_base;
  logic [W-1:0] w_new_term;
  logic [W-1:0] w_res;
  logic [W-1:0] w_acc;

  assign w_is_digit = (in >= 8'd48) && (in <= 8'd57);
  // '0'..'9' carry their value in the low nibble.
  assign w_digit    = W'(in[3:0]);

`ifdef EXPR_EVAL_OVF_EN
  logic         r_ovf;
  logic         w_ovf_mul;
  logic         w_ovf_digit;
  logic         w_ovf_add;
  logic [W+3:0] w_prod_wide;
  logic [W:0]   w_res_wide;
  logic [W:0]   w_acc_wide;

  assign w_prod_wide = {4'b0000, r_term} * {{W{1'b0}}, in[3:0]};
  assign w_acc_wide  = {1'b0, r_sum} + {1'b0, r_term};
  assign w_acc       = w_acc_wide[W-1:0];
  assign w_ovf_add   = w_acc_wide[W];
`else
  assign w_acc = r_sum + r_term;
`endif

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_base     = (r_state == S_START) ? '0 : r_sum;
    w_new_term = w_digit;
`ifdef EXPR_EVAL_OVF_EN
    w_ovf_mul  = 1'b0;
    if (r_state == S_MUL) begin
      w_new_term = w_prod_wide[W-1:0];
      w_ovf_mul  = |w_prod_wide[W+3:W];
    end
`else
    if (r_state == S_MUL) begin
      w_new_term = r_term * w_digit;
    end
`endif
  end

`ifdef EXPR_EVAL_OVF_EN
  assign w_res_wide  = {1'b0, w_base} + {1'b0, w_new_term};
  assign w_res       = w_res_wide[W-1:0];
  assign w_ovf_digit = w_ovf_mul | w_res_wide[W];
`else
  assign w_res = w_base + w_new_term;
`endif

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_START;
      r_sum     <= '0;
      r_term    <= '0;
      r_result  <= '0;
      r_res_vld <= 1'b0;
      r_err     <= 1'b0;
`ifdef EXPR_EVAL_OVF_EN
      r_ovf     <= 1'b0;
`endif
    end else if (in_vld && (r_state != S_ERR)) begin
      case (r_state)
        S_START, S_ADD, S_MUL: begin
          if (w_is_digit) begin
            r_state   <= S_NUM;
            r_sum     <= w_base;
            r_term    <= w_new_term;
            r_result  <= w_res;
            r_res_vld <= 1'b1;
`ifdef EXPR_EVAL_OVF_EN
            r_ovf     <= r_ovf | w_ovf_digit;
`endif
          end else begin
            r_state   <= S_ERR;
            r_err     <= 1'b1;
            r_res_vld <= 1'b0;
          end
        end
        S_NUM: begin
          r_res_vld <= 1'b0;
          if (in == 8'd43) begin
            r_state <= S_ADD;
            r_sum   <= w_acc;
`ifdef EXPR_EVAL_OVF_EN
            r_ovf   <= r_ovf | w_ovf_add;
`endif
          end else if (in == 8'd42) begin
            r_state <= S_MUL;
          end else begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_ERR;
          r_err     <= 1'b1;
          r_res_vld <= 1'b0;
        end
      endcase
    end
  end

  assign result  = r_result;
  assign res_vld = r_res_vld;
  assign err     = r_err;
`ifdef EXPR_EVAL_OVF_EN
  assign ovf     = r_ovf;
`else
  assign ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: a driver pushes expected outputs per accepted edge,
// a monitor pops and compares one clock later; idle cycles must leave outputs unchanged.
module tb_expr_eval;

  localparam int W = 16;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  typedef struct packed {
    logic [W-1:0] res;
    logic         vld;
    logic         err;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic [7:0]   in = 8'd0;
  logic         in_vld = 1'b0;
  logic [W-1:0] result;
  logic         res_vld;
  logic         err;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];

  // Reference model state: the accepted expression text since the last clr.
  byte          m_text[$];
  bit           m_err;
  bit           m_vld;
  logic [W-1:0] m_res;
  bit           m_ovf;

  expr_eval #(.W(W)) dut (
    .clk(clk), .clr(clr), .in(in), .in_vld(in_vld),
    .result(result), .res_vld(res_vld), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got result=%0d vld=%0b err=%0b ovf=%0b, want result=%0d vld=%0b err=%0b ovf=%0b",
               name, act.res, act.vld, act.err, act.ovf, exp.res, exp.vld, exp.err, exp.ovf);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t o;
    o.res = result; o.vld = res_vld; o.err = err; o.ovf = ovf;
    return o;
  endfunction

  function automatic exp_t model_out();
    exp_t o;
    o.res = m_res; o.vld = m_vld; o.err = m_err;
`ifdef EXPR_EVAL_OVF_EN
    o.ovf = m_ovf;
`else
    o.ovf = 1'b0;
`endif
    return o;
  endfunction

  function automatic void model_reset();
    m_text.delete();
    m_err = 0; m_vld = 0; m_res = '0; m_ovf = 0;
  endfunction

  // Evaluates the whole accepted text from scratch with precedence: terms are products, summed.
  function automatic void model_accept(input byte c);
    bit want_digit, is_dig, is_op;
    longint unsigned s, t, r;
    bit o;
    if (m_err) return;
    want_digit = (m_text.size() % 2) == 0;
    is_dig = (c >= 8'd48) && (c <= 8'd57);
    is_op  = (c == "+") || (c == "*");
    if ((want_digit && !is_dig) || (!want_digit && !is_op)) begin
      m_err = 1; m_vld = 0;
      return;
    end
    m_text.push_back(c);
    if (!want_digit) begin
      m_vld = 0;
      return;
    end
    s = 0; t = 0; o = 0;
    for (int i = 0; i < m_text.size(); i += 2) begin
      longint unsigned d = longint'(m_text[i] - 8'd48);
      if (i == 0) t = d;
      else if (m_text[i-1] == "+") begin
        s = s + t;
        if (s > MASK) o = 1;
        s = s & MASK;
        t = d;
      end else begin
        t = t * d;
        if (t > MASK) o = 1;
        t = t & MASK;
      end
    end
    r = s + t;
    if (r > MASK) o = 1;
    m_res = W'(r & MASK);
    m_vld = 1;
    m_ovf = m_ovf | o;
  endfunction

  task automatic send(input byte c);
    @(negedge clk);
    clr = 0; in = c; in_vld = 1;
    model_accept(c);
    exp_q.push_back(model_out());
    @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clr = 0; in_vld = 0; in = 8'($urandom);
    end
  endtask

  task automatic do_clr(input bit with_char, input byte c);
    @(negedge clk);
    clr = 1; in_vld = with_char; in = c;
    model_reset();
    exp_q.push_back(model_out());
    @(posedge clk);
  endtask

  task automatic expect_now(input string name, input int r, input bit v, input bit e, input bit o);
    exp_t x;
    x.res = W'(r); x.vld = v; x.err = e; x.ovf = o;
    check(name, dut_out(), x);
  endtask

  // Monitor: each edge that consumed a character or clr owes one scoreboard entry.
  initial begin
    exp_t last;
    bit have_last = 0;
    bit acc;
    forever begin
      @(posedge clk);
      acc = clr || in_vld;
      #1;
      if (acc) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL scoreboard_underflow: output edge with no expected entry");
        end else begin
          last = exp_q.pop_front();
          have_last = 1;
          check("scoreboard", dut_out(), last);
        end
      end else if (have_last) begin
        check("idle_stable", dut_out(), last);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ovf_on;
`ifdef EXPR_EVAL_OVF_EN
    ovf_on = 1;
`else
    ovf_on = 0;
`endif
    model_reset();
    do_clr(0, 8'd0);
    idle(1);
    expect_now("reset_state", 0, 0, 0, 0);

    send_str("1+2*3"); idle(1);
    expect_now("prec_1+2*3", 7, 1, 0, 0);

    do_clr(0, 8'd0);
    send("2"); idle(2); send("*"); idle(2); send("3"); idle(2);
    send("+"); idle(2); send("4"); idle(2);
    expect_now("gaps_2*3+4", 10, 1, 0, 0);

    do_clr(0, 8'd0);
    send("5"); idle(1); expect_now("after_5", 5, 1, 0, 0);
    send("+"); idle(1); expect_now("after_plus", 5, 0, 0, 0);
    send("7"); idle(1); expect_now("after_7", 12, 1, 0, 0);

    do_clr(0, 8'd0);
    send_str("12"); idle(1); expect_now("double_digit", 1, 0, 1, 0);
    send_str("+3"); idle(2); expect_now("err_absorbs", 1, 0, 1, 0);

    do_clr(0, 8'd0);
    send_str("9*9*9*9*9"); idle(1); expect_now("pow5", 59049, 1, 0, 0);
    send_str("*9"); idle(1); expect_now("pow6_wrap", 7153, 1, 0, ovf_on);

    do_clr(0, 8'd0);
    send("3"); do_clr(1, "*"); idle(1);
    expect_now("clr_beats_char", 0, 0, 0, 0);
    send("4"); idle(1); expect_now("after_clr_4", 4, 1, 0, 0);

    // Randomized expressions: mostly well-formed, some junk, random gaps and mid-stream clr.
    for (int e = 0; e < 60; e++) begin
      int len;
      do_clr(0, 8'd0);
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        byte c;
        int pick = $urandom_range(0, 99);
        if (pick < 6) c = byte'($urandom_range(32, 126));
        else if (pick < 10) c = (k % 2 == 0) ? "+" : byte'(8'd48 + $urandom_range(0, 9));
        else if (k % 2 == 0) c = byte'(8'd48 + $urandom_range(0, 9));
        else c = ($urandom_range(0, 1) != 0) ? "*" : "+";
        if ($urandom_range(0, 39) == 0) do_clr($urandom_range(0, 1) != 0, c);
        else send(c);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(1);
    end

    idle(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
